imem_boot_loader: RTL and testbench

Upstream of the processor core: streams program words into instruction memory, holding the core in reset until the image is loaded. Accepts 16-bit words over a valid/ready handshake and writes them to consecutive instruction-memory addresses starting at 0. After the last write commits, it releases the core reset so fetch begins at PC 0. Supports reload (re-enter reset and reload) without a global reset.

---
 rtl/imem_boot_loader_pkg.sv | 19 +
 rtl/imem_load_counter.sv | 50 +++++
 rtl/imem_boot_loader.sv | 184 ++++++++++++++++++
 tb/tb_imem_boot_loader.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/imem_boot_loader_pkg.sv
// Shared types and default sizes for the instruction-memory boot loader.
// Contents: loader state enum and the default DATA_W / ADDR_W / DEPTH values.
package imem_boot_loader_pkg;

    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned DEF_ADDR_W = 8;
    localparam int unsigned DEF_DEPTH  = 256;

    // Loader states; CHECK is only reachable with IMEM_LOADER_CHECKSUM_EN.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_FLUSH = 3'd2,
        ST_CHECK = 3'd3,
        ST_RUN   = 3'd4,
        ST_ERROR = 3'd5
    } state_t;

endpackage

// File: rtl/imem_load_counter.sv
// Write-address counter for the boot loader.
// Holds the latched load length and the running word count (ADDR_W+1 bits so
// a full DEPTH-word image never wraps), and flags when the current count is
// the final word of the image.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   clr         return count to zero (length is kept)
//   inc         advance count by one
//   len_ld/len  latch a new load length
//   addr        low ADDR_W bits of the registered count
//   is_last_c   combinational: count == latched length - 1
module imem_load_counter
    import imem_boot_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              inc,
    input  logic              len_ld,
    input  logic [ADDR_W:0]   len,
    output logic [ADDR_W-1:0] addr,
    output logic              is_last_c
);

    logic [ADDR_W:0] count_q;
    logic [ADDR_W:0] len_q;

    // Count and length registers; clear has priority over increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            len_q   <= '0;
        end else begin
            if (len_ld) begin
                len_q <= len;
            end
            if (clr) begin
                count_q <= '0;
            end else if (inc) begin
                count_q <= count_q + (ADDR_W+1)'(1);
            end
        end
    end

    assign addr      = count_q[ADDR_W-1:0];
    assign is_last_c = (count_q == (len_q - (ADDR_W+1)'(1)));

endmodule

// File: rtl/imem_boot_loader.sv
// Instruction-memory boot loader.
// Streams DATA_W-bit words from a valid/ready source into instruction memory
// at addresses 0..load_len-1 while holding the core in reset, then releases
// core_rst. A reload request from RUN or ERROR returns to IDLE without a
// global reset.
// Optional build macro: IMEM_LOADER_CHECKSUM_EN adds a trailing checksum word
// (16-bit wrap-around sum of the image), checked in a CHECK state.
// Ports:
//   clk, proc_rst         clock, synchronous active-high system reset
//   start, load_len       begin a load of load_len words (IDLE only)
//   reload                return to IDLE (RUN / ERROR only)
//   in_valid, in_data     stream word in; in_ready is the registered accept
//   imem_we/addr/wdata    instruction-memory write port
//   core_rst              processor reset, high until the image is loaded
//   busy, done, error     status: loading, running, rejected/bad image
module imem_boot_loader
    import imem_boot_loader_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DEPTH  = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              proc_rst,
    input  logic              start,
    input  logic [ADDR_W:0]   load_len,
    input  logic              reload,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              core_rst,
    output logic              busy,
    output logic              done,
    output logic              error
);

    state_t            state;
    logic              take_c;
    logic              len_bad_c;
    logic              cnt_clr_c;
    logic              cnt_inc_c;
    logic              cnt_ld_c;
    logic              is_last_c;
    logic [ADDR_W-1:0] cnt_addr;

    // in_ready is a registered, state-derived flag, so a handshake never
    // depends combinationally on in_valid.
    assign take_c    = in_valid & in_ready;
    assign len_bad_c = (load_len == '0) || (load_len > (ADDR_W+1)'(DEPTH));

    // Counter sits at zero throughout IDLE and is cleared on the reload edge.
    assign cnt_clr_c = (state == ST_IDLE) ||
                       (((state == ST_RUN) || (state == ST_ERROR)) && reload);
    assign cnt_inc_c = (state == ST_LOAD) && take_c;
    assign cnt_ld_c  = (state == ST_IDLE) && start;

    imem_load_counter #(
        .ADDR_W (ADDR_W)
    ) u_counter (
        .clk       (clk),
        .rst       (proc_rst),
        .clr       (cnt_clr_c),
        .inc       (cnt_inc_c),
        .len_ld    (cnt_ld_c),
        .len       (load_len),
        .addr      (cnt_addr),
        .is_last_c (is_last_c)
    );

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q;

    // Wrap-around sum of image words, restarted every time we pass IDLE.
    always_ff @(posedge clk) begin
        if (proc_rst || (state == ST_IDLE)) begin
            sum_q <= '0;
        end else if ((state == ST_LOAD) && take_c) begin
            sum_q <= sum_q + in_data;
        end
    end
`endif

    // Loader FSM; every output is set on the edge that enters its state.
    always_ff @(posedge clk) begin
        if (proc_rst) begin
            state      <= ST_IDLE;
            core_rst   <= 1'b1;
            in_ready   <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (len_bad_c) begin
                            state <= ST_ERROR;
                            error <= 1'b1;
                        end else begin
                            state    <= ST_LOAD;
                            in_ready <= 1'b1;
                            busy     <= 1'b1;
                        end
                    end
                end

                ST_LOAD: begin
                    if (take_c) begin
                        imem_we    <= 1'b1;
                        imem_addr  <= cnt_addr;
                        imem_wdata <= in_data;
                        if (is_last_c) begin
                            state    <= ST_FLUSH;
                            in_ready <= 1'b0;
                        end
                    end
                end

                // Final write is on the bus this cycle.
                ST_FLUSH: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state    <= ST_CHECK;
                    in_ready <= 1'b1;
`else
                    state    <= ST_RUN;
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    core_rst <= 1'b0;
`endif
                end

`ifdef IMEM_LOADER_CHECKSUM_EN
                // Trailer word is compared, never written to memory.
                ST_CHECK: begin
                    if (take_c) begin
                        in_ready <= 1'b0;
                        busy     <= 1'b0;
                        if (in_data == sum_q) begin
                            state    <= ST_RUN;
                            done     <= 1'b1;
                            core_rst <= 1'b0;
                        end else begin
                            state <= ST_ERROR;
                            error <= 1'b1;
                        end
                    end
                end
`endif

                ST_RUN: begin
                    if (reload) begin
                        state    <= ST_IDLE;
                        core_rst <= 1'b1;
                        done     <= 1'b0;
                    end
                end

                ST_ERROR: begin
                    if (reload) begin
                        state <= ST_IDLE;
                        error <= 1'b0;
                    end
                end

                default: begin
                    state    <= ST_IDLE;
                    core_rst <= 1'b1;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                    error    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader (default build, checksum disabled).
// A vector table gives per-cycle inputs and the registered outputs expected
// just after that clock edge; a hand-written full-depth load follows.
module tb_imem_boot_loader;

    logic        clk = 1'b0;
    logic        proc_rst;
    logic        start;
    logic [8:0]  load_len;
    logic        reload;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [15:0] imem_wdata;
    logic        core_rst;
    logic        busy;
    logic        done;
    logic        error;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    imem_boot_loader dut (
        .clk        (clk),
        .proc_rst   (proc_rst),
        .start      (start),
        .load_len   (load_len),
        .reload     (reload),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_rst   (core_rst),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    typedef struct {
        logic        rst;
        logic        start;
        logic [8:0]  len;
        logic        reload;
        logic        valid;
        logic [15:0] data;
        logic        rdy;
        logic        we;
        logic [7:0]  addr;
        logic [15:0] wdata;
        logic        crst;
        logic        busy;
        logic        done;
        logic        err;
    } vec_t;

    vec_t vecs[$];

    task automatic put(input int rst, input int st, input int len, input int rl,
                       input int vld, input int dat, input int rdy, input int we,
                       input int addr, input int wd, input int crst, input int bsy,
                       input int dn, input int err);
        vec_t v;
        v.rst   = 1'(rst);
        v.start = 1'(st);
        v.len   = 9'(len);
        v.reload = 1'(rl);
        v.valid = 1'(vld);
        v.data  = 16'(dat);
        v.rdy   = 1'(rdy);
        v.we    = 1'(we);
        v.addr  = 8'(addr);
        v.wdata = 16'(wd);
        v.crst  = 1'(crst);
        v.busy  = 1'(bsy);
        v.done  = 1'(dn);
        v.err   = 1'(err);
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        proc_rst = 1'b1; start = 1'b0; load_len = '0; reload = 1'b0;
        in_valid = 1'b0; in_data = '0;

        // rst st len rl vld data | rdy we addr wdata crst busy done err
        // Reset, idle, in_valid in IDLE ignored
        put(1,0,0,0,0,0,          0,0,0,0,1,0,0,0);
        put(0,0,0,0,0,0,          0,0,0,0,1,0,0,0);
        put(0,0,0,0,1,'h9999,     0,0,0,0,1,0,0,0);
        // 3-word load, valid held high
        put(0,1,3,0,0,0,          1,0,0,0,1,1,0,0);
        put(0,0,0,0,1,'h1111,     1,1,0,'h1111,1,1,0,0);
        put(0,0,0,0,1,'h2222,     1,1,1,'h2222,1,1,0,0);
        put(0,0,0,0,1,'h3333,     0,1,2,'h3333,1,1,0,0);
        put(0,0,0,0,1,'h4444,     0,0,2,'h3333,0,0,1,0);
        put(0,0,0,0,0,0,          0,0,2,'h3333,0,0,1,0);
        put(0,1,1,0,0,0,          0,0,2,'h3333,0,0,1,0);
        put(0,0,0,1,0,0,          0,0,2,'h3333,1,0,0,0);
        // 3-word load, valid toggling; reload during LOAD ignored
        put(0,1,3,0,0,0,          1,0,2,'h3333,1,1,0,0);
        put(0,0,0,0,1,'hAAAA,     1,1,0,'hAAAA,1,1,0,0);
        put(0,0,0,1,0,'hDEAD,     1,0,0,'hAAAA,1,1,0,0);
        put(0,0,0,0,1,'hBBBB,     1,1,1,'hBBBB,1,1,0,0);
        put(0,0,0,0,0,0,          1,0,1,'hBBBB,1,1,0,0);
        put(0,0,0,0,1,'hCCCC,     0,1,2,'hCCCC,1,1,0,0);
        put(0,0,0,0,0,0,          0,0,2,'hCCCC,0,0,1,0);
        put(0,0,0,1,0,0,          0,0,2,'hCCCC,1,0,0,0);
        // Bad lengths 0 and 257; start/valid ignored in ERROR
        put(0,1,0,0,0,0,          0,0,2,'hCCCC,1,0,0,1);
        put(0,1,3,0,1,'h5555,     0,0,2,'hCCCC,1,0,0,1);
        put(0,0,0,1,0,0,          0,0,2,'hCCCC,1,0,0,0);
        put(0,1,257,0,0,0,        0,0,2,'hCCCC,1,0,0,1);
        put(0,0,0,1,0,0,          0,0,2,'hCCCC,1,0,0,0);
        // proc_rst after 2 of 4 words, then a 2-word load from address 0
        put(0,1,4,0,0,0,          1,0,2,'hCCCC,1,1,0,0);
        put(0,0,0,0,1,'h0101,     1,1,0,'h0101,1,1,0,0);
        put(0,0,0,0,1,'h0202,     1,1,1,'h0202,1,1,0,0);
        put(1,0,0,0,1,'h0303,     0,0,0,0,1,0,0,0);
        put(0,1,2,0,0,0,          1,0,0,0,1,1,0,0);
        put(0,0,0,0,1,'h0A0A,     1,1,0,'h0A0A,1,1,0,0);
        put(0,0,0,0,1,'h0B0B,     0,1,1,'h0B0B,1,1,0,0);
        put(0,0,0,0,0,0,          0,0,1,'h0B0B,0,0,1,0);
        // Reload from RUN, then a 1-word load
        put(0,0,0,1,0,0,          0,0,1,'h0B0B,1,0,0,0);
        put(0,1,1,0,0,0,          1,0,1,'h0B0B,1,1,0,0);
        put(0,0,0,0,1,'h0C0C,     0,1,0,'h0C0C,1,1,0,0);
        put(0,0,0,0,0,0,          0,0,0,'h0C0C,0,0,1,0);
        put(0,0,0,1,0,0,          0,0,0,'h0C0C,1,0,0,0);
        put(0,0,0,1,1,'h7777,     0,0,0,'h0C0C,1,0,0,0);

        foreach (vecs[i]) begin
            proc_rst = vecs[i].rst;
            start    = vecs[i].start;
            load_len = vecs[i].len;
            reload   = vecs[i].reload;
            in_valid = vecs[i].valid;
            in_data  = vecs[i].data;
            step();
            check($sformatf("v%0d.in_ready", i), 32'(in_ready), 32'(vecs[i].rdy));
            check($sformatf("v%0d.imem_we", i), 32'(imem_we), 32'(vecs[i].we));
            check($sformatf("v%0d.imem_addr", i), 32'(imem_addr), 32'(vecs[i].addr));
            check($sformatf("v%0d.imem_wdata", i), 32'(imem_wdata), 32'(vecs[i].wdata));
            check($sformatf("v%0d.core_rst", i), 32'(core_rst), 32'(vecs[i].crst));
            check($sformatf("v%0d.busy", i), 32'(busy), 32'(vecs[i].busy));
            check($sformatf("v%0d.done", i), 32'(done), 32'(vecs[i].done));
            check($sformatf("v%0d.error", i), 32'(error), 32'(vecs[i].err));
        end

        // Full-depth load: 256 words, final address 255, no wrap
        proc_rst = 1'b0; reload = 1'b0; in_valid = 1'b0;
        start = 1'b1; load_len = 9'd256;
        step();
        check("full.start_ready", 32'(in_ready), 32'd1);
        start = 1'b0; load_len = '0;
        for (int i = 0; i < 256; i++) begin
            in_valid = 1'b1;
            in_data  = 16'(i) ^ 16'hA5A5;
            step();
            check($sformatf("full%0d.we", i), 32'(imem_we), 32'd1);
            check($sformatf("full%0d.addr", i), 32'(imem_addr), 32'(i));
            check($sformatf("full%0d.wdata", i), 32'(imem_wdata), 32'(16'(i) ^ 16'hA5A5));
            check($sformatf("full%0d.ready", i), 32'(in_ready), (i == 255) ? 32'd0 : 32'd1);
        end
        in_valid = 1'b1; in_data = 16'h1234;
        step();
        check("full.flush_we", 32'(imem_we), 32'd0);
        check("full.flush_core_rst", 32'(core_rst), 32'd0);
        check("full.run_done", 32'(done), 32'd1);
        check("full.last_addr", 32'(imem_addr), 32'd255);
        check("full.last_wdata", 32'(imem_wdata), 32'(16'd255 ^ 16'hA5A5));
        in_valid = 1'b0;
        step();
        check("full.run_hold", 32'(core_rst), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
